// File: rtl/bit_serializer.sv
// bit_serializer: loads an 8-bit word and shifts it out one bit every DIV clocks.
// The bit order is set at build time by SERIALIZER_LSB_FIRST_EN. It is MSB-first when that macro is undefined.
module bit_serializer #(
  parameter int unsigned DIV = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] din,
  input  logic       load,
  output logic       ready,
  output logic       x,
  output logic       x_valid,
  output logic       done
);

  typedef enum logic {IDLE, SEND} state_t;

  // The prescaler is kept at least one bit wide, so DIV=1 still works.
  // With DIV=1 the prescaler stays at 0, and 0 is also its last count.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  state_t        state, state_next;
  logic [7:0]    sh, sh_next, sh_shifted;
  logic [2:0]    bit_cnt, bit_next;
  logic [PW-1:0] pre, pre_next;
  logic          head;

`ifdef SERIALIZER_LSB_FIRST_EN
  assign head       = sh[0];
  assign sh_shifted = {1'b0, sh[7:1]};
`else
  assign head       = sh[7];
  assign sh_shifted = {sh[6:0], 1'b0};
`endif

  // NOTE: every signal gets a default first, so no path can leave one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sh_next    = sh;
    bit_next   = bit_cnt;
    pre_next   = pre;
    ready      = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_next = SEND;
          sh_next    = din;
          bit_next   = 3'd0;
          pre_next   = '0;
        end
      end
      SEND: begin
        x = head;
        if (pre == PRE_LAST) begin
          x_valid  = 1'b1;
          pre_next = '0;
          sh_next  = sh_shifted;
          bit_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end else begin
          pre_next = pre + PRE_ONE;
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments, so every register sees the values from before the edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      sh      <= '0;
      bit_cnt <= '0;
      pre     <= '0;
    end else begin
      state   <= state_next;
      sh      <= sh_next;
      bit_cnt <= bit_next;
      pre     <= pre_next;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer. It uses three instances, with DIV=1, DIV=2 and DIV=3.
// The bit-order build is chosen by SERIALIZER_LSB_FIRST_EN, the same macro the RTL uses.
module tb_bit_serializer;

  logic       Clock;
  logic       Reset;
  logic [2:0] load;
  logic [7:0] din [3];
  logic [2:0] ready, x, x_valid, done;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.DIV(1)) u_div1 (.Clock(Clock), .Reset(Reset), .din(din[0]), .load(load[0]),
    .ready(ready[0]), .x(x[0]), .x_valid(x_valid[0]), .done(done[0]));
  bit_serializer #(.DIV(2)) u_div2 (.Clock(Clock), .Reset(Reset), .din(din[1]), .load(load[1]),
    .ready(ready[1]), .x(x[1]), .x_valid(x_valid[1]), .done(done[1]));
  bit_serializer #(.DIV(3)) u_div3 (.Clock(Clock), .Reset(Reset), .din(din[2]), .load(load[2]),
    .ready(ready[2]), .x(x[2]), .x_valid(x_valid[2]), .done(done[2]));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Each vector holds the stream expected on x. Bit 7 of the stream is the first bit sent.
  typedef struct {
    logic [7:0] din;
    logic [7:0] msb_s;
    logic [7:0] lsb_s;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [7:0] pick(input vec_t v);
`ifdef SERIALIZER_LSB_FIRST_EN
    return v.lsb_s;
`else
    return v.msb_s;
`endif
  endfunction

  // Loads one word into instance k and checks every SEND cycle. It then checks the IDLE cycle that follows.
  task automatic run_word(input int k, input int div, input logic [7:0] d, input logic [7:0] s,
                          input string tag);
    int guard;
    guard = 0;
    while (ready[k] !== 1'b1 && guard < 64) begin
      tick();
      guard++;
    end
    check({tag, " ready_before_load"}, {7'd0, ready[k]}, 8'd1);
    din[k]  = d;
    load[k] = 1'b1;
    tick();
    load[k] = 1'b0;
    din[k]  = ~d;
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < div; p++) begin
        check($sformatf("%s x b%0d p%0d", tag, b, p), {7'd0, x[k]}, {7'd0, s[7-b]});
        check($sformatf("%s x_valid b%0d p%0d", tag, b, p), {7'd0, x_valid[k]},
              {7'd0, (p == div - 1)});
        check($sformatf("%s done b%0d p%0d", tag, b, p), {7'd0, done[k]},
              {7'd0, (p == div - 1) && (b == 7)});
        check($sformatf("%s ready b%0d p%0d", tag, b, p), {7'd0, ready[k]}, 8'd0);
        tick();
      end
    end
    check({tag, " ready_after"}, {7'd0, ready[k]}, 8'd1);
    check({tag, " x_after"}, {7'd0, x[k]}, 8'd0);
  endtask

  initial begin
    logic [7:0] s;
    vecs[0] = '{din: 8'hCC, msb_s: 8'b11001100, lsb_s: 8'b00110011};
    vecs[1] = '{din: 8'hA5, msb_s: 8'b10100101, lsb_s: 8'b10100101};
    vecs[2] = '{din: 8'hF0, msb_s: 8'b11110000, lsb_s: 8'b00001111};
    vecs[3] = '{din: 8'h03, msb_s: 8'b00000011, lsb_s: 8'b11000000};
    vecs[4] = '{din: 8'h81, msb_s: 8'b10000001, lsb_s: 8'b10000001};
    vecs[5] = '{din: 8'h5A, msb_s: 8'b01011010, lsb_s: 8'b01011010};

    load = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #1;
    check("reset ready", {5'd0, ready}, 8'h07);
    check("reset x", {5'd0, x}, 8'h00);
    check("reset x_valid", {5'd0, x_valid}, 8'h00);
    check("reset done", {5'd0, done}, 8'h00);
    tick();
    tick();
    #2 Reset = 1'b1;
    tick();

    // Run every table vector on the DIV=1 instance. Run selected vectors on DIV=3 and DIV=2.
    for (int i = 0; i < 6; i++)
      run_word(0, 1, vecs[i].din, pick(vecs[i]), $sformatf("div1 v%0d", i));
    run_word(2, 3, vecs[1].din, pick(vecs[1]), "div3 A5");
    run_word(1, 2, vecs[5].din, pick(vecs[5]), "div2 5A");

    // A load while the block is busy is ignored. The first word plays out unchanged.
    s = pick(vecs[2]);
    din[0]  = 8'hF0;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    check("busy x c1", {7'd0, x[0]}, {7'd0, s[7]});
    din[0]  = 8'h0F;
    load[0] = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      if (c == 7) load[0] = 1'b0;
      tick();
      check($sformatf("busy x c%0d", c), {7'd0, x[0]}, {7'd0, s[8-c]});
      check($sformatf("busy ready c%0d", c), {7'd0, ready[0]}, 8'd0);
    end
    check("busy done c8", {7'd0, done[0]}, 8'd1);
    tick();
    check("busy ready c9", {7'd0, ready[0]}, 8'd1);

    // With load held high, a new word starts every 9 cycles. Each word takes the din present at its accepting edge.
    din[0]  = vecs[0].din;
    load[0] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      s = pick(vecs[w]);
      tick();
      din[0] = vecs[w + 1].din ^ 8'hFF;
      for (int c = 1; c <= 8; c++) begin
        check($sformatf("cont w%0d x c%0d", w, c), {7'd0, x[0]}, {7'd0, s[8-c]});
        check($sformatf("cont w%0d done c%0d", w, c), {7'd0, done[0]}, {7'd0, c == 8});
        tick();
      end
      check($sformatf("cont w%0d idle ready", w), {7'd0, ready[0]}, 8'd1);
      check($sformatf("cont w%0d idle x", w), {7'd0, x[0]}, 8'd0);
      din[0] = vecs[w + 1].din;
    end
    load[0] = 1'b0;
    tick();

    // Reset in the middle of a DIV=2 word aborts it at once, with no done pulse. Reset also wins over load.
    s = pick(vecs[1]);
    din[1]  = 8'hA5;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    check("abort x c5", {7'd0, x[1]}, {7'd0, s[5]});
    check("abort ready c5", {7'd0, ready[1]}, 8'd0);
    #2 Reset = 1'b0;
    #1;
    check("abort ready async", {7'd0, ready[1]}, 8'd1);
    check("abort x async", {7'd0, x[1]}, 8'd0);
    check("abort x_valid async", {7'd0, x_valid[1]}, 8'd0);
    check("abort done async", {7'd0, done[1]}, 8'd0);
    load[1] = 1'b1;
    tick();
    check("reset beats load", {7'd0, ready[1]}, 8'd1);
    load[1] = 1'b0;
    #2 Reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("post abort done %0d", c), {7'd0, done[1]}, 8'd0);
      check($sformatf("post abort ready %0d", c), {7'd0, ready[1]}, 8'd1);
      check($sformatf("post abort x %0d", c), {7'd0, x[1]}, 8'd0);
    end
    run_word(1, 2, vecs[1].din, pick(vecs[1]), "div2 after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DIV, default 1: bit period in Clock cycles; legal range 1..256.
REQ-002 Port Clock  input  1: single clock; all state updates on its rising edge.
REQ-003 Port Reset  input  1: asynchronous, active-low reset.
REQ-004 Port din  input  8: parallel word to serialize, sampled only on an accepted load.
REQ-005 Port load  input  1: load request; a load is accepted on a rising edge where load=1 and ready=1.
REQ-006 Port ready  output  1: high only in IDLE; the block can accept a load.
REQ-007 Port x  output  1: serial bit stream, suitable to drive the pattern detector's x input directly.
REQ-008 Port x_valid  output  1: one-cycle strobe in the last cycle of each bit period.
REQ-009 Port done  output  1: one-cycle pulse in the last cycle of the final bit period of a word.

Function
REQ-010 The FSM SHALL have two states: IDLE and SEND.
REQ-011 In IDLE: ready=1, x=0, x_valid=0, done=0.
REQ-012 An accepted load SHALL capture din into an 8-bit shift register, clear the bit counter (0..7) and prescaler (0..DIV-1), and enter SEND on the same edge.
REQ-013 In SEND: ready=0; x SHALL equal the current head bit of the shift register (MSB-first by default).
REQ-014 Each bit SHALL be held on x for exactly DIV consecutive cycles; the first bit appears the cycle after the accepting edge.
REQ-015 x_valid SHALL be 1 only when prescaler=DIV-1 in SEND; on that edge the register shifts, the bit counter increments, and the prescaler returns to 0.
REQ-016 With DIV=1, the prescaler SHALL be degenerate: x_valid=1 in every SEND cycle, one new bit per clock.
REQ-017 done SHALL be 1 in the cycle where bit counter=7 and x_valid=1; the next edge returns to IDLE.
REQ-018 A word SHALL occupy exactly 8*DIV SEND cycles, followed by at least one IDLE cycle before the next word's first bit.
REQ-019 load while ready=0 SHALL be ignored with no effect on din capture, counters or outputs.
REQ-020 din changes outside an accepting edge SHALL NOT affect x.
REQ-021 All outputs SHALL be registered or decoded from registered state only, with no combinational path from load or din.

Reset
REQ-022 Reset=0 SHALL immediately force IDLE, shift register=0, counters=0, ready=1, x=0, x_valid=0, done=0.
REQ-023 Reset asserted mid-word SHALL abort the word with no done pulse; after release, the block waits in IDLE for a new load.
REQ-024 Reset has priority over load on the same edge.

Configuration
REQ-025 Macro SERIALIZER_LSB_FIRST_EN: when defined, bits SHALL be sent LSB-first (din[0] first, right shift); when undefined, MSB-first (din[7] first, left shift).
REQ-026 The macro SHALL change only bit order; timing, handshake and reset behaviour are identical in both builds.

Verification
REQ-027 DIV=1, load din=8'hCC at edge E0 -> x=1,1,0,0,1,1,0,0 in cycles 1..8; x_valid=1 in cycles 1..8; done=1 only in cycle 8; ready=1 from cycle 9. Feeding x to the detector yields y=1 after each 1100 run.
REQ-028 DIV=3, din=8'hA5 -> each bit is held 3 cycles (1,0,1,0,0,1,0,1); x_valid in cycles 3,6,...,24; done in cycle 24; ready=0 in cycles 1..24.
REQ-029 DIV=1, din=8'hF0 accepted, then load=1 with din=8'h0F in cycles 2..6 -> output remains 1,1,1,1,0,0,0,0 with no restart; a new load is accepted only after ready returns to 1.
REQ-030 DIV=2, Reset=0 asynchronously in cycle 5 of a word -> all outputs reach reset values before the next edge; no done pulse; after release ready=1 and x=0 until the next load.
REQ-031 SERIALIZER_LSB_FIRST_EN defined, DIV=1, din=8'h03 -> x=1,1,0,0,0,0,0,0; done in cycle 8.
REQ-032 Load held high continuously with DIV=1 -> words start every 9 cycles (8 SEND + 1 IDLE), and each accepts the din present at its accepting edge.
